// File: rtl/oap_ram_pkg.sv
// Shared constants and request record for arbiters in front of the 4096x32 block RAM.
package oap_ram_pkg;

    localparam int RAM_AW    = 12;
    localparam int RAM_DW    = 32;
    localparam int MAX_PORTS = 8;

    typedef struct packed {
        logic              rnw;
        logic              lock;
        logic [RAM_AW-1:0] addr;
        logic [RAM_DW-1:0] wdata;
    } ram_req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request from ptr upward, or only the owner when masked.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          mask_en,
    input  logic [IW-1:0] owner,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    always_comb begin
        int            sum;
        logic [IW-1:0] j;
        logic          found;
        gnt   = '0;
        idx   = '0;
        sum   = 0;
        j     = '0;
        found = 1'b0;
        if (mask_en) begin
            if (req[owner]) begin
                gnt[owner] = 1'b1;
                idx        = owner;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                sum = int'(ptr) + k;
                if (sum >= N) sum = sum - N;
                j = IW'(sum);
                if (!found && req[j]) begin
                    found  = 1'b1;
                    gnt[j] = 1'b1;
                    idx    = j;
                end
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port block RAM among NPORTS requesters, with locked bursts.
module ram_port_arbiter
    import oap_ram_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int AW     = RAM_AW,
    parameter int DW     = RAM_DW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NPORTS-1:0] req,
    input  logic [NPORTS-1:0] rnw,
    input  logic [NPORTS-1:0] lock,
    input  logic [NPORTS*AW-1:0] addr,
    input  logic [NPORTS*DW-1:0] wdata,
    output logic [NPORTS-1:0] gnt,
    output logic [NPORTS-1:0] rvalid,
    output logic [DW-1:0]     rdata,
    output logic              ram_cs,
    output logic              ram_rnw,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout
);

    localparam int IW = (NPORTS > 2) ? $clog2(NPORTS) : 1;

    if (NPORTS < 2 || NPORTS > MAX_PORTS) begin : g_bad_nports
        $error("ram_port_arbiter: NPORTS must be in 2..8");
    end

    logic [IW-1:0]     ptr;
    logic              owner_vld;
    logic [IW-1:0]     owner_id;
    logic [NPORTS-1:0] rv_q;
    logic [NPORTS-1:0] pick_gnt;
    logic [IW-1:0]     win;
    logic              rd_sel;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (int'(i) == NPORTS - 1) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(
        .N  (NPORTS),
        .IW (IW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .mask_en (owner_vld),
        .owner   (owner_id),
        .gnt     (pick_gnt),
        .idx     (win)
    );

    // Reset gates the grant combinationally so the RAM sees no access while it is held.
    assign gnt    = pick_gnt & {NPORTS{~reset}};
    assign ram_cs = |gnt;
    assign rvalid = rv_q;
    assign rdata  = ram_dout;

    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        rd_sel   = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            ram_addr = ram_addr | (addr[i*AW +: AW] & {AW{gnt[i]}});
            ram_din  = ram_din  | (wdata[i*DW +: DW] & {DW{gnt[i]}});
            rd_sel   = rd_sel   | (rnw[i] & gnt[i]);
        end
    end

    assign ram_rnw = rd_sel | ~ram_cs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            owner_vld <= 1'b0;
            owner_id  <= '0;
            rv_q      <= '0;
        end else begin
            rv_q <= gnt & rnw;
            if (|gnt) begin
                if (lock[win]) begin
                    owner_vld <= 1'b1;
                    owner_id  <= win;
                    if (!owner_vld) ptr <= next_idx(win);
                end else begin
                    owner_vld <= 1'b0;
                    ptr       <= next_idx(win);
                end
            end else if (owner_vld && !req[owner_id]) begin
                // Owner walked away without finishing the burst: free the RAM this edge.
                owner_vld <= 1'b0;
                ptr       <= next_idx(owner_id);
            end
        end
    end

endmodule
